// File: rtl/odd_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : odd_parity_checker
//  Description : Odd-parity check of a 5-bit received word {a,b,c,d,p}.
//                A combinational error flag is produced on every input change.
//                A registered statistics stage records the flag per valid
//                frame, counts frames and errors (saturating) and keeps a
//                sticky error bit.
//  Revision    : 1.0  initial release
// ============================================================================
module odd_parity_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             p,
    input  logic             in_valid,
    input  logic             clr_stats,
    output logic             pec,
    output logic             pec_q,
    output logic             out_valid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Saturation value shared by both counters.
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             last_pec_q,  last_pec_d;
    logic             valid_q,     valid_d;
    logic             sticky_q,    sticky_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    // Odd parity: an even number of ones (including zero) is an error.
    // Kept as a plain reduction so X/Z on any input reaches the flag.
    assign pec = ~(a ^ b ^ c ^ d ^ p);

    // Next-state for the statistics stage; a clear takes priority over
    // counting, while the flag register and output pulse still follow the
    // current frame.
    always_comb begin
        last_pec_d  = last_pec_q;
        valid_d     = in_valid;
        sticky_d    = sticky_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (in_valid) begin
            last_pec_d = pec;
        end

        if (clr_stats) begin
            sticky_d    = 1'b0;
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else if (in_valid) begin
            if (frame_cnt_q != C_CNT_MAX) begin
                frame_cnt_d = frame_cnt_q + C_CNT_ONE;
            end
            if (pec) begin
                sticky_d = 1'b1;
                if (err_cnt_q != C_CNT_MAX) begin
                    err_cnt_d = err_cnt_q + C_CNT_ONE;
                end
            end
        end
    end

    // Statistics registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pec_q  <= 1'b0;
            valid_q     <= 1'b0;
            sticky_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            last_pec_q  <= last_pec_d;
            valid_q     <= valid_d;
            sticky_q    <= sticky_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pec_q      = last_pec_q;
    assign out_valid  = valid_q;
    assign err_sticky = sticky_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_odd_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odd_parity_checker
//  Description : Scoreboard bench for odd_parity_checker. Two instances share
//                stimulus: default width and CNT_W=2 for saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_odd_parity_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a = 0, b = 0, c = 0, d = 0, p = 0;
    logic        in_valid = 0, clr_stats = 0;

    logic        pec, pec_q, out_valid, err_sticky;
    logic [15:0] frame_cnt, err_cnt;
    logic        pec2, pec_q2, out_valid2, err_sticky2;
    logic [1:0]  frame_cnt2, err_cnt2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit e_pec;
        int e_frame;
        int e_err;
        bit e_sticky;
        int e_frame2;
        int e_err2;
        bit e_sticky2;
    } exp_t;

    exp_t sb_q[$];

    // Reference state: plain integer counts clamped to the counter ceiling.
    int mf = 0, me = 0, mf2 = 0, me2 = 0;
    bit ms = 0, ms2 = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    odd_parity_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr_stats(clr_stats),
        .pec(pec), .pec_q(pec_q), .out_valid(out_valid),
        .err_sticky(err_sticky), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    odd_parity_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr_stats(clr_stats),
        .pec(pec2), .pec_q(pec_q2), .out_valid(out_valid2),
        .err_sticky(err_sticky2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_error(input logic [4:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        mf = 0; me = 0; ms = 0; mf2 = 0; me2 = 0; ms2 = 0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus just after a rising edge and record what
    // the DUT must show after the next rising edge.
    task automatic issue(input logic [4:0] v, input logic vld, input logic clr);
        exp_t e;
        bit   err;
        @(posedge clk);
        #1;
        {a, b, c, d, p} = v;
        in_valid  = vld;
        clr_stats = clr;
        err = ref_error(v);
        #1;
        chk("pec_live", pec, err);
        if (clr) begin
            mf = 0; me = 0; ms = 0; mf2 = 0; me2 = 0; ms2 = 0;
        end else if (vld) begin
            mf  = sat(mf + 1, 65535);
            mf2 = sat(mf2 + 1, 3);
            if (err) begin
                me  = sat(me + 1, 65535);
                me2 = sat(me2 + 1, 3);
                ms  = 1;
                ms2 = 1;
            end
        end
        if (vld) begin
            e.e_pec = err;
            e.e_frame = mf;  e.e_err = me;  e.e_sticky = ms;
            e.e_frame2 = mf2; e.e_err2 = me2; e.e_sticky2 = ms2;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        issue(5'($urandom_range(0, 31)), 1'b0, 1'b0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_frame"},  frame_cnt,  mf);
        chk({tag, "_err"},    err_cnt,    me);
        chk({tag, "_sticky"}, err_sticky, ms);
        chk({tag, "_frame2"}, frame_cnt2, mf2);
        chk({tag, "_err2"},   err_cnt2,   me2);
    endtask

    // Monitor: every output pulse consumes one expected entry.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("ov_match", out_valid2, out_valid);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("pec_q",      pec_q,       e.e_pec);
                    chk("frame_cnt",  frame_cnt,   e.e_frame);
                    chk("err_cnt",    err_cnt,     e.e_err);
                    chk("err_sticky", err_sticky,  e.e_sticky);
                    chk("pec_q2",     pec_q2,      e.e_pec);
                    chk("frame_cnt2", frame_cnt2,  e.e_frame2);
                    chk("err_cnt2",   err_cnt2,    e.e_err2);
                    chk("sticky2",    err_sticky2, e.e_sticky2);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Combinational sweep, in reset, no frames qualified.
        for (int v = 0; v < 32; v++) begin
            {a, b, c, d, p} = 5'(v);
            #20;
            chk("sweep_pec", pec, ref_error(5'(v)));
        end
        // Reset values.
        chk("rst_pec_q", pec_q, 0);
        chk("rst_out_valid", out_valid, 0);
        check_stats("rst");

        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // Valid stream: pec_q 0,1,0,1; 4 frames, 2 errors.
        issue(5'b00001, 1, 0);
        issue(5'b00000, 1, 0);
        issue(5'b11100, 1, 0);
        issue(5'b11110, 1, 0);
        idle();
        idle();
        chk("stream_frame", frame_cnt, 4);
        chk("stream_err", err_cnt, 2);
        chk("stream_sticky", err_sticky, 1);

        // Gaps: only qualified error frames count.
        issue(5'b00000, 1, 0);
        issue(5'b00000, 0, 0);
        issue(5'b00000, 1, 0);
        idle();
        idle();
        chk("gap_err", err_cnt, 4);
        chk("gap_frame", frame_cnt, 6);

        // Clear collides with a valid error frame.
        issue(5'b00000, 1, 1);
        idle();
        #3;
        chk("clr_frame", frame_cnt, 0);
        chk("clr_err", err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        chk("clr_pec_q", pec_q, 1);

        // Saturation on the narrow instance.
        repeat (5) issue(5'b00000, 1, 0);
        idle();
        idle();
        chk("sat_frame2", frame_cnt2, 3);
        chk("sat_err2", err_cnt2, 3);
        chk("sat_frame16", frame_cnt, 5);

        // Asynchronous reset mid-cycle with nonzero counters.
        issue(5'b10110, 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pec_q", pec_q, 0);
        chk("arst_out_valid", out_valid, 0);
        check_stats("arst");
        {a, b, c, d, p} = 5'b11000;
        #1;
        chk("arst_pec_live", pec, 1);
        {a, b, c, d, p} = 5'b10000;
        #1;
        chk("arst_pec_live2", pec, 0);
        in_valid = 0;
        clr_stats = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            issue(5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();
        check_stats("final");
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/odd_parity_checker.md
Name: odd_parity_checker

Overview:
Checks a 5-bit received word (data bits a, b, c, d plus parity bit p) against odd parity. Combinational error flag pec asserts when the total count of 1s is even. A clocked statistics stage registers the flag per valid frame and keeps frame/error counts plus a sticky error bit. Sits at the receive side of a serial/parallel link, ahead of error-reporting logic.

Parameters:
CNT_W, 16, width of frame and error counters (>=2)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
a  in  1  data bit 3 (MSB)
b  in  1  data bit 2
c  in  1  data bit 1
d  in  1  data bit 0
p  in  1  received odd-parity bit
in_valid  in  1  frame qualifier for statistics stage
clr_stats  in  1  synchronous clear of counters and sticky flag
pec  out  1  combinational parity error: 1 = even count of 1s among a,b,c,d,p
pec_q  out  1  registered pec of last valid frame
out_valid  out  1  one-cycle pulse, pec_q updated
err_sticky  out  1  set by any errored valid frame, held until clear
frame_cnt  out  CNT_W  valid frames seen, saturating
err_cnt  out  CNT_W  errored valid frames, saturating

Behaviour:
- pec = ~(a ^ b ^ c ^ d ^ p); purely combinational, no clock or reset dependency; settles same delta as inputs change, independent of in_valid.
- pec = 0 for odd number of 1s (1, 3, 5); pec = 1 for 0, 2, 4.
- X/Z on any input propagates to pec as X (no masking).
- Reset (rst_n = 0, asynchronous assert, synchronous-to-clk deassert by system): pec_q = 0, out_valid = 0, err_sticky = 0, frame_cnt = 0, err_cnt = 0.
- Each rising clk with in_valid = 1: pec_q <= pec; out_valid <= 1; frame_cnt += 1; if pec then err_cnt += 1 and err_sticky <= 1. Latency one cycle from sampled inputs to pec_q/out_valid.
- in_valid = 0: out_valid <= 0; pec_q, counters, sticky hold.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr_stats = 1 at a clock edge: frame_cnt, err_cnt, err_sticky cleared to 0. If in_valid = 1 same cycle, clear wins for counters/sticky; pec_q/out_valid still update from current frame. Then next frame counts from 0.
- Reset asserted mid-stream: all registered outputs go to reset values immediately; pec continues to follow inputs.

Test Plan:
- Exhaustive combinational sweep: all 32 {a,b,c,d,p} values, 20 ns each, no clock -> pec = 1 for 00000, 01001, 11000, 11110, 11011; pec = 0 for 00001, 01000, 11111, 10000; matches ~XOR in all 32.
- Reset: drive rst_n = 0 asynchronously mid-cycle with counters nonzero -> all registered outputs 0 immediately; pec still tracks inputs.
- Valid stream: 4 frames {00001, 00000, 11100, 11110} with in_valid = 1 -> pec_q sequence 0,1,0,1 one cycle late, out_valid high 4 cycles, frame_cnt = 4, err_cnt = 2, err_sticky = 1.
- Gaps: in_valid toggled 1,0,1 with error frame 00000 then 00000 -> out_valid 1,0,1; err_cnt increments only on valid cycles (=2).
- Clear collision: clr_stats = 1 with in_valid = 1, frame 00000 -> counters 0, err_sticky 0, pec_q = 1, out_valid = 1.
- Saturation with CNT_W = 2: 5 errored valid frames -> frame_cnt = err_cnt = 3, held.
